// File: rtl/mul_seq_if.sv
// Request/response bundle between the core FSM and the iterative multiplier.
// Pure wiring, no latency of its own.
// No backpressure: requests while busy are dropped by the slave.
interface mul_seq_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             Long;
   logic             Signed;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] ResultLo;
   logic [WIDTH-1:0] ResultHi;

   // Core FSM side: issues operands, observes status and results
   modport master (
      output Start, SrcA, SrcB, Long, Signed,
      input  Busy, Done, ResultLo, ResultHi
   );

   // Multiplier side
   modport slave (
      input  Start, SrcA, SrcB, Long, Signed,
      output Busy, Done, ResultLo, ResultHi
   );
endinterface

// File: rtl/mul_seq.sv
// Shift-add multiply sequencer (MUL/UMULL/SMULL); optional MUL_EARLY_EXIT_EN macro.
// Latency: Done in cycle WIDTH+2 after Start (early-exit build: CALC length + 2).
// Backpressure: Busy high from cycle 1 through DONE; Start while not IDLE is ignored.
module mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      reset,
   mul_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t               r_state;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [CW-1:0]        r_cnt;
   logic                 r_neg;
   logic                 r_long;
   logic                 r_busy;
   logic                 r_done;
   logic [WIDTH-1:0]     r_res_lo;
   logic [WIDTH-1:0]     r_res_hi;

   // Magnitudes are only taken for SMULL; MUL/UMULL operands pass through untouched.
   // The most negative value maps to 2^(W-1), which still fits unsigned.
   logic                 w_sgn;
   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [2*WIDTH-1:0]   w_acc_add;
   logic [2*WIDTH-1:0]   w_acc_fix;
   logic                 w_calc_last;

   assign w_sgn     = bus.Signed & bus.Long;
   assign w_abs_a   = (w_sgn & bus.SrcA[WIDTH-1]) ? (~bus.SrcA + 1'b1) : bus.SrcA;
   assign w_abs_b   = (w_sgn & bus.SrcB[WIDTH-1]) ? (~bus.SrcB + 1'b1) : bus.SrcB;
   assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_acc_fix = r_neg ? (~r_acc + 1'b1) : r_acc;

`ifdef MUL_EARLY_EXIT_EN
   // Stop once no multiplier bits remain after this cycle's shift
   assign w_calc_last = (r_cnt == CW'(1)) || (r_mplier[WIDTH-1:1] == '0);
`else
   assign w_calc_last = (r_cnt == CW'(1));
`endif

   // Sequencer FSM with registered status and result outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_long   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_res_lo <= '0;
         r_res_hi <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.Start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                  r_mplier <= w_abs_b;
                  r_acc    <= '0;
                  r_neg    <= w_sgn & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
                  r_cnt    <= CW'(WIDTH);
                  r_long   <= bus.Long;
                  r_busy   <= 1'b1;
                  r_state  <= S_CALC;
               end
            end
            S_CALC: begin
               r_acc    <= w_acc_add;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt - 1'b1;
               if (w_calc_last) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               // Sign correction and result capture share the FIX->DONE edge
               r_acc    <= w_acc_fix;
               r_res_lo <= w_acc_fix[WIDTH-1:0];
               r_res_hi <= r_long ? w_acc_fix[2*WIDTH-1:WIDTH] : '0;
               r_done   <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.Busy     = r_busy;
   assign bus.Done     = r_done;
   assign bus.ResultLo = r_res_lo;
   assign bus.ResultHi = r_res_hi;
endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative multiply sequencer for the multicycle ARM core. The main FSM issues a multiply-class instruction (MUL, UMULL, SMULL) with a one-cycle `Start` pulse. The block then runs a shift-add multiply over several cycles, reporting `Busy` so the FSM holds in its execute state. On `Done`, the FSM writes `ResultLo`/`ResultHi` back through the result mux.

## Interface
- `WIDTH`, default 32: operand width; product is 2*WIDTH.
- `clk  in  1`: system clock; all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `Start  in  1`: one-cycle request; sampled only in IDLE.
- `SrcA  in  WIDTH`: multiplicand (Rm).
- `SrcB  in  WIDTH`: multiplier (Rs).
- `Long  in  1`: 1 = 64-bit result (UMULL/SMULL); 0 = MUL.
- `Signed  in  1`: 1 = operands are two's complement (SMULL); ignored when `Long`=0.
- `Busy  out  1`: high whenever state is not IDLE.
- `Done  out  1`: one-cycle pulse; results valid.
- `ResultLo  out  WIDTH`: product bits [WIDTH-1:0].
- `ResultHi  out  WIDTH`: product bits [2W-1:W]; forced 0 when `Long`=0.

## Operation
- The FSM has four states: IDLE, CALC, FIX and DONE.
- **IDLE**
  - On `Start`=1, latch `Mcand` = |SrcA| zero-extended to 2W, and `Mplier` = |SrcB|.
  - Clear `Acc`, set `Neg` = Signed & Long & (SrcA[W-1] ^ SrcB[W-1]), set `Cnt` = WIDTH, latch `Long`, then go to CALC.
  - Absolute value applies only when Signed & Long; otherwise operands pass through unchanged.
  - |-2^(W-1)| = 2^(W-1) is representable unsigned.
- **CALC**, once per cycle:
  - If `Mplier[0]`, then `Acc` += `Mcand` (2W-bit add, carry discarded).
  - `Mcand` <<= 1, `Mplier` >>= 1, `Cnt` -= 1.
  - Leave to FIX on the cycle in which `Cnt` becomes 0.
- **FIX**: `Acc` = `Neg` ? -`Acc` : `Acc` (2W two's complement), then go to DONE.
- **DONE**: `ResultLo` = Acc[W-1:0] and `ResultHi` = Long ? Acc[2W-1:W] : 0; these registers load on the FIX->DONE edge. `Done`=1 for this cycle, then go to IDLE.
- Results hold their value until the next FIX->DONE edge.
- `Start` while `Busy`=1 is ignored: no queueing, no error.
- `Start` in the DONE cycle is ignored, because the state is not IDLE.
- Input operands are not used after the Start cycle and may change freely.

## Timing
- Reset (asynchronous, `reset`=0) puts the FSM in IDLE and clears all of the following:
  - `Busy`=0, `Done`=0, `ResultLo`=0, `ResultHi`=0;
  - `Acc`, `Mcand`, `Mplier`, `Cnt`, `Neg`.
- Reset mid-operation aborts immediately. No `Done` is produced, and the outputs read 0.
- Cycle numbering: the Start cycle is cycle 0.
- `Busy` is high in cycles 1 through the DONE cycle inclusive.
- Latency, default build: CALC occupies WIDTH cycles, then 1 FIX cycle. `Done` is high in cycle WIDTH+2 (34 for WIDTH=32).
- Back-to-back issue: the earliest next accepted `Start` is in the cycle after DONE.
- Throughput is one multiply per WIDTH+3 cycles.

## Configuration
- Macro: `MUL_EARLY_EXIT_EN`.
- **Defined**: CALC also exits to FIX at the end of any cycle whose post-shift `Mplier` is 0.
  - CALC length = max(1, index of the MSB of the effective multiplier + 1).
  - `Done` cycle = CALC length + 2.
- **Undefined**: fixed WIDTH-cycle CALC with deterministic latency; the `Mplier`==0 compare is not synthesized.
- Results are identical in both builds.

## Test plan
- **Short unsigned multiply**: SrcA=3, SrcB=5, Long=0 -> `Done` at cycle 34 with ResultLo=0x0000000F and ResultHi=0; `Busy` high in cycles 1-34.
- **Signed long, negative result**: SrcA=0xFFFFFFFE (-2), SrcB=3, Long=1, Signed=1 -> ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFFA.
- **Unsigned long, all ones**: SrcA=SrcB=0xFFFFFFFF, Long=1, Signed=0 -> ResultHi=0xFFFFFFFE, ResultLo=0x00000001.
  - The same operands with Signed=1 give ResultHi=0, ResultLo=1.
- **Start while busy**: pulse `Start` with new operands at cycle 10 during a 7*9 operation -> result 63 at cycle 34; no second `Done` follows.
- **Reset mid-CALC**: drive `reset`=0 at cycle 15 -> `Busy`, `Done` and the results go to 0 immediately; after release, a new Start of 2*2 yields 4 at cycle 34.
- **Early exit** (`MUL_EARLY_EXIT_EN` defined):
  - SrcB=1 -> `Done` at cycle 3.
  - SrcB=0 -> `Done` at cycle 3 with result 0.
  - SrcB=0x80000000 -> `Done` at cycle 34.
